// File: rtl/neuron_stream.sv
// neuron_stream: streaming N_IN-tap neuron, y = act(sum x*w + bias).
// Optional macro NEURON_LEAKY_EN selects leaky ReLU instead of plain ReLU.
//
// Ports:
//   clk, rst            clock, async active-high reset
//   sync_clr            synchronous abort of the sample in progress
//   in_valid/in_ready   tap handshake, carries x, w (and bias on tap 0)
//   out_valid/out_ready result handshake, carries y
//   tap_idx             index of the next tap to be accepted
module neuron_stream #(
  parameter int DATA_W     = 8,
  parameter int N_IN       = 4,
  parameter int LEAK_SHIFT = 3,
  localparam int ACC_W     = 2*DATA_W + $clog2(N_IN),
  localparam int OUT_W     = ACC_W + 1,
  localparam int TAP_W     = $clog2(N_IN)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sync_clr,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] x,
  input  logic signed [DATA_W-1:0] w,
  input  logic signed [DATA_W-1:0] bias,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [OUT_W-1:0]  y,
  output logic [TAP_W-1:0]         tap_idx
);

  typedef enum logic [1:0] {
    ACCUM, SUM, ACT, HOLD
  } state_t;

  state_t                   state;
  logic signed [ACC_W-1:0]  acc;
  logic signed [DATA_W-1:0] bias_q;
  logic signed [OUT_W-1:0]  sum;

  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    prod_x;
  logic                       last_tap;
  logic signed [OUT_W-1:0]    act_val;

  assign prod     = x * w;
  assign prod_x   = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
  assign last_tap = (tap_idx == TAP_W'(N_IN - 1));
  assign in_ready = (state == ACCUM);

`ifdef NEURON_LEAKY_EN
  // Arithmetic shift floors negative sums toward -inf.
  assign act_val = sum[OUT_W-1] ? (sum >>> LEAK_SHIFT) : sum;
`else
  assign act_val = sum[OUT_W-1] ? '0 : sum;
  // The leak amount has no role in plain ReLU.
  logic unused_leak;
  assign unused_leak = ^LEAK_SHIFT;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ACCUM;
      acc       <= '0;
      bias_q    <= '0;
      sum       <= '0;
      tap_idx   <= '0;
      out_valid <= 1'b0;
      y         <= '0;
    end else begin
      unique case (state)
        ACCUM: begin
          if (sync_clr) begin
            acc     <= '0;
            tap_idx <= '0;
          end else if (in_valid) begin
            // Tap 0 starts a fresh sample and latches its bias.
            if (tap_idx == '0) begin
              acc    <= prod_x;
              bias_q <= bias;
            end else begin
              acc <= acc + prod_x;
            end
            if (last_tap) begin
              tap_idx <= '0;
              state   <= SUM;
            end else begin
              tap_idx <= tap_idx + TAP_W'(1);
            end
          end
        end
        SUM: begin
          if (sync_clr) begin
            acc   <= '0;
            state <= ACCUM;
          end else begin
            sum <= {acc[ACC_W-1], acc}
                 + {{(OUT_W-DATA_W){bias_q[DATA_W-1]}}, bias_q};
            state <= ACT;
          end
        end
        ACT: begin
          if (sync_clr) begin
            acc   <= '0;
            state <= ACCUM;
          end else begin
            y         <= act_val;
            out_valid <= 1'b1;
            state     <= HOLD;
          end
        end
        HOLD: begin
          // Result is committed; sync_clr cannot retract it.
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_stream.sv
// tb_neuron_stream: randomized self-checking bench for neuron_stream.
// Expected results come from an integer reference model of the neuron.
module tb_neuron_stream;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               sync_clr = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [7:0]  x = '0;
  logic signed [7:0]  w = '0;
  logic signed [7:0]  bias = '0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic signed [18:0] y;
  logic [1:0]         tap_idx;

  int checks = 0;
  int errors = 0;

  neuron_stream #(
    .DATA_W(8), .N_IN(4), .LEAK_SHIFT(3)
  ) dut (
    .clk(clk), .rst(rst), .sync_clr(sync_clr),
    .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .w(w), .bias(bias),
    .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .tap_idx(tap_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint got,
                     input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  function automatic longint model(input int xs[4], input int ws[4],
                                   input int b);
    longint s = longint'(b);
    for (int i = 0; i < 4; i++) s += longint'(xs[i]) * longint'(ws[i]);
`ifdef NEURON_LEAKY_EN
    return (s < 0) ? (s >>> 3) : s;
`else
    return (s < 0) ? 0 : s;
`endif
  endfunction

  task automatic idle(input int k);
    repeat (k) @(negedge clk);
  endtask

  // Called and returns just after a falling edge.
  task automatic put_tap(input int xv, input int wv, input int bv);
    int n = 0;
    x = 8'(xv);
    w = 8'(wv);
    bias = 8'(bv);
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_out();
    int n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run_sample(input int xs[4], input int ws[4],
                            input int b, input int gap_max,
                            input int hold_max, input string tag);
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      put_tap(xs[i], ws[i], (i == 0) ? b : int'($urandom_range(255, 0)) - 128);
      if (i < 3) idle(int'($urandom_range(gap_max, 0)));
    end
    wait_out();
    chk({tag, "_v"}, longint'(out_valid), 1);
    chk(tag, longint'(y), model(xs, ws, b));
    idle(int'($urandom_range(hold_max, 0)));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_rel"}, longint'(out_valid), 0);
  endtask

  int xs[4];
  int ws[4];
  int b;
  longint hold_y;

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ov", longint'(out_valid), 0);
    chk("rst_y", longint'(y), 0);
    chk("rst_tap", longint'(tap_idx), 0);
    chk("rst_ir", longint'(in_ready), 1);
    rst = 1'b0;
    @(negedge clk);

    // Test 1: exact latency and one-cycle pulse
    xs = '{1, 2, 3, 4};
    ws = '{1, 1, 1, 1};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) put_tap(xs[i], ws[i], -5);
    chk("t1_ir_busy", longint'(in_ready), 0);
    chk("t1_ov_e1", longint'(out_valid), 0);
    @(negedge clk);
    chk("t1_ov_e2", longint'(out_valid), 0);
    @(negedge clk);
    chk("t1_ov_e3", longint'(out_valid), 1);
    chk("t1_y", longint'(y), 5);
    @(negedge clk);
    chk("t1_pulse", longint'(out_valid), 0);
    chk("t1_ir_back", longint'(in_ready), 1);
    out_ready = 1'b0;

    // Test 2: large negative sum
    xs = '{-128, -128, -128, -128};
    ws = '{127, 127, 127, 127};
    run_sample(xs, ws, -128, 0, 0, "t2");
`ifdef NEURON_LEAKY_EN
    chk("t2_lit", longint'(y), -8144);
`else
    chk("t2_lit", longint'(y), 0);
`endif

    // Test 3: maximum positive result
    xs = '{-128, -128, -128, -128};
    ws = '{-128, -128, -128, -128};
    run_sample(xs, ws, 127, 0, 0, "t3");
    chk("t3_lit", longint'(y), 65663);

    // Test 4: backpressure, taps ignored while holding
    xs = '{10, -20, 30, 5};
    ws = '{3, 4, -1, 7};
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) put_tap(xs[i], ws[i], 9);
    wait_out();
    hold_y = longint'(y);
    chk("t4_y", hold_y, model(xs, ws, 9));
    for (int c = 0; c < 10; c++) begin
      x = 8'($urandom);
      w = 8'($urandom);
      in_valid = 1'b1;
      sync_clr = (c == 5);
      @(negedge clk);
      chk("t4_hold_ov", longint'(out_valid), 1);
      chk("t4_hold_y", longint'(y), hold_y);
      chk("t4_hold_ir", longint'(in_ready), 0);
    end
    in_valid = 1'b0;
    sync_clr = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("t4_rel", longint'(out_valid), 0);
    chk("t4_tap", longint'(tap_idx), 0);
    xs = '{1, 2, 3, 4};
    ws = '{5, 6, 7, 8};
    run_sample(xs, ws, -3, 0, 0, "t4_next");

    // Test 5: sync_clr mid-sample, then clean sample
    put_tap(7, 7, 100);
    put_tap(7, 7, 0);
    put_tap(7, 7, 0);
    chk("t5_tap3", longint'(tap_idx), 3);
    sync_clr = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    sync_clr = 1'b0;
    in_valid = 1'b0;
    chk("t5_clr_tap", longint'(tap_idx), 0);
    xs = '{2, 2, 2, 2};
    ws = '{3, 3, 3, 3};
    run_sample(xs, ws, 0, 0, 0, "t5");
    chk("t5_lit", longint'(y), 24);

    // Test 5b: sync_clr in SUM aborts the sample
    hold_y = longint'(y);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) put_tap(50, 50, 50);
    sync_clr = 1'b1;
    @(negedge clk);
    sync_clr = 1'b0;
    chk("t5b_ir", longint'(in_ready), 1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("t5b_no_ov", longint'(out_valid), 0);
    end
    chk("t5b_y", longint'(y), hold_y);

    // Test 5c: async reset while in SUM
    for (int i = 0; i < 4; i++) put_tap(9, 9, 9);
    #2 rst = 1'b1;
    #1;
    chk("t5c_ov", longint'(out_valid), 0);
    chk("t5c_y", longint'(y), 0);
    chk("t5c_ir", longint'(in_ready), 1);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("t5c_no_ov", longint'(out_valid), 0);
    end
    out_ready = 1'b0;

    // Test 6: in_valid gaps 1-0-1-0-0-1-1
    put_tap(1, 1, -5);
    chk("t6_tap1", longint'(tap_idx), 1);
    idle(1);
    chk("t6_tap1_hold", longint'(tap_idx), 1);
    put_tap(2, 1, 0);
    idle(2);
    chk("t6_tap2_hold", longint'(tap_idx), 2);
    put_tap(3, 1, 0);
    put_tap(4, 1, 0);
    wait_out();
    chk("t6_y", longint'(y), 5);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Randomized samples
    for (int s = 0; s < 40; s++) begin
      for (int i = 0; i < 4; i++) begin
        xs[i] = int'($urandom_range(255, 0)) - 128;
        ws[i] = int'($urandom_range(255, 0)) - 128;
      end
      b = int'($urandom_range(255, 0)) - 128;
      run_sample(xs, ws, b, 2, 3, "rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
